csr_regfile: RTL
================

# csr_regfile

Parametrised control/status register file with a valid/ready request channel and a separate response channel. It succeeds the flat config/status register map and adds several features:
- per-bit reset values;
- self-clearing command bits;
- sticky write-1-to-clear status bits with an input synchroniser;
- per-register write strobes;
- error responses.

It sits between the host bus bridge (SPI/UART command decoder) and the analog/digital configuration and status buses of the chip.

## Interface
- ADDR_WIDTH, 7: address bits. Requires NUM_CONFIG_REG+NUM_STATUS_REG <= 2^ADDR_WIDTH.
- DATA_WIDTH, 8: register width.
- NUM_CONFIG_REG, 96: config registers at addresses 0..NUM_CONFIG_REG-1.
- NUM_STATUS_REG, 32: status registers at addresses NUM_CONFIG_REG..NUM_CONFIG_REG+NUM_STATUS_REG-1.
- CONFIG_RESET, register 0 = 0xCC and all others 0: packed reset values, DATA_WIDTH*NUM_CONFIG_REG bits.
- CONFIG_SC_MASK, all 0: packed mask; 1 marks a self-clearing config bit.
- STATUS_STICKY_MASK, all 0: packed mask; 1 marks a sticky W1C status bit, 0 a live bit.
- SYNC_STAGES, 2: synchroniser depth on status_bus_i, 0..3. 0 means no synchroniser.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_write_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  register address.
- write_data_i  in  DATA_WIDTH  write data.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when resp_valid_o && resp_ready_i.
- resp_data_o  out  DATA_WIDTH  read data. Always 0 for writes.
- resp_err_o  out  1  access error.
- config_bus_o  out  DATA_WIDTH*NUM_CONFIG_REG  config register contents; register i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- cfg_wr_stb_o  out  NUM_CONFIG_REG  one-cycle strobe per config register on a successful write.
- status_bus_i  in  DATA_WIDTH*NUM_STATUS_REG  raw status inputs, possibly asynchronous; same packing as config_bus_o.

## Operation
- The FSM has two states:
  - IDLE: req_ready_o=1. An accepted request is executed on the accepting edge, and the FSM moves to RESP.
  - RESP: req_ready_o=0, resp_valid_o=1. When resp_ready_i=1 the FSM returns to IDLE.
- Only one transaction is outstanding at a time.
- Config write, addr < NUM_CONFIG_REG:
  - The register takes write_data_i on the accept edge.
  - The matching cfg_wr_stb_o bit is 1 for the next cycle.
  - resp_err_o=0.
- Config read returns the register value at the accept cycle, err=0.
- Status read, addr - NUM_CONFIG_REG = j:
  - Returns the status word j value at the accept cycle: sticky bits come from the sticky register, live bits from the synchronised input.
  - err=0.
- Status write:
  - Every sticky bit written with 1 is cleared.
  - Bits written with 0, and all live bits, are unchanged.
  - err=0 if the register has at least one sticky bit; otherwise err=1 and nothing changes.
- Out-of-range address, read or write:
  - No state change.
  - resp_data_o = all ones for reads, 0 for writes.
  - err=1.
- Sticky bits are set on every cycle the synchronised input bit is 1. If a W1C clear and a set land on the same edge, the set wins.
- Self-clearing config bits read back the written value for exactly one cycle after the write, then return to 0 on the next edge. Non-SC bits of the same register keep their written value.
- resp_data_o and resp_err_o are registered and stable throughout RESP.

## Timing
- Reset values:
  - FSM = IDLE, req_ready_o=1, resp_valid_o=0, resp_data_o=0, resp_err_o=0.
  - config_bus_o = CONFIG_RESET.
  - cfg_wr_stb_o=0.
  - Sticky bits = 0; synchroniser flops = 0.
- Latency:
  - A request accepted at edge N gives resp_valid_o=1 in cycle N+1.
  - The earliest next accept is edge N+2, so a back-to-back transfer with resp_ready_i=1 takes 2 cycles.
  - config_bus_o updates after edge N.
  - cfg_wr_stb_o is high for cycle N+1 only.
  - Self-clearing bits drop after edge N+1.
- Status latency: a change on status_bus_i is visible after SYNC_STAGES edges. Sticky bits set one edge after that.
- Request inputs are ignored while req_ready_o=0.
- Reset asserted mid-transaction aborts it immediately. No response is produced, and all state returns to its reset values.

## Test plan
- Reset: assert rst_i asynchronously mid-RESP.
  - resp_valid_o drops without waiting for a clock.
  - config_bus_o[7:0]=0xCC, all other bits 0; req_ready_o=1.
- Write then read back: write 0x5A to addr 3, then read addr 3.
  - cfg_wr_stb_o[3] pulses for 1 cycle.
  - The read response gives data 0x5A, err=0.
  - The response holds while resp_ready_i=0 for 5 cycles.
- Self-clear: CONFIG_SC_MASK bit0 of reg 1 = 1; write 0xFF to addr 1.
  - config_bus_o[15:8] shows 0xFF for one cycle, then 0xFE.
- Sticky W1C: STATUS_STICKY_MASK reg 0 = 0x0F; pulse status bit 2 for one cycle.
  - A read of addr 96 returns 0x04.
  - Write 0x04, then read again: returns 0x00.
  - Hold bit 2 high during the clear: it still reads 0x04.
- Errors:
  - A read of addr 127 (config+status = 128, so 127 is in range) returns the status word. Re-parameterise to 64+32 and read addr 100: data 0xFF, err=1.
  - A write to an all-live status register gives err=1.
- Synchroniser latency: with SYNC_STAGES=2, toggle a live status bit and read continuously.
  - The new value first appears in a read accepted 2 edges after the toggle.

Source files
------------

// File: rtl/csr_regfile.sv
// csr_regfile: valid/ready CSR file with self-clearing config bits, sticky W1C status and error responses
`timescale 1ns/1ps
module csr_regfile #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CONFIG_REG = 96,
    parameter int NUM_STATUS_REG = 32,
    parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CONFIG_RESET = (DATA_WIDTH*NUM_CONFIG_REG)'(8'hCC),
    parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CONFIG_SC_MASK = '0,
    parameter logic [DATA_WIDTH*NUM_STATUS_REG-1:0] STATUS_STICKY_MASK = '0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_write_i,
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    input  logic [DATA_WIDTH-1:0]                write_data_i,
    output logic                                 resp_valid_o,
    input  logic                                 resp_ready_i,
    output logic [DATA_WIDTH-1:0]                resp_data_o,
    output logic                                 resp_err_o,
    output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o,
    output logic [NUM_CONFIG_REG-1:0]            cfg_wr_stb_o,
    input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i
);
    localparam int CW = DATA_WIDTH*NUM_CONFIG_REG;
    localparam int SW = DATA_WIDTH*NUM_STATUS_REG;
    localparam logic [ADDR_WIDTH:0] CFG_N = (ADDR_WIDTH+1)'(NUM_CONFIG_REG);
    localparam logic [ADDR_WIDTH:0] END_N = (ADDR_WIDTH+1)'(NUM_CONFIG_REG+NUM_STATUS_REG);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]                state_q;
    logic [CW-1:0]             cfg_q, cfg_d;
    logic [NUM_CONFIG_REG-1:0] stb_d;
    logic [SW-1:0]             sync, sticky_q, clr, sts_word;
    logic [ADDR_WIDTH:0]       a_ext, sidx;
    logic                      is_cfg, is_sts, acc, has_sticky;
    logic [DATA_WIDTH-1:0]     cfg_rd, sts_rd;

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign acc          = req_valid_i && req_ready_o;
    assign a_ext        = {1'b0, addr_i};
    assign is_cfg       = a_ext < CFG_N;
    assign is_sts       = !is_cfg && a_ext < END_N;
    assign sidx         = a_ext - CFG_N;
    assign sts_word     = (sticky_q & STATUS_STICKY_MASK) | (sync & ~STATUS_STICKY_MASK);
    assign config_bus_o = cfg_q;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sync = status_bus_i;
    end else begin : g_sync
        logic [SW-1:0] sq [SYNC_STAGES];
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k < SYNC_STAGES; k++) sq[k] <= '0;
            end else begin
                sq[0] <= status_bus_i;
                for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
            end
        end
        assign sync = sq[SYNC_STAGES-1];
    end

    // wrapped sidx for config addresses can never match a status index
    always_comb begin
        cfg_d      = cfg_q & ~CONFIG_SC_MASK;
        stb_d      = '0;
        clr        = '0;
        cfg_rd     = '0;
        sts_rd     = '0;
        has_sticky = 1'b0;
        for (int i = 0; i < NUM_CONFIG_REG; i++) begin
            if (a_ext == (ADDR_WIDTH+1)'(i)) begin
                cfg_rd = cfg_q[DATA_WIDTH*i +: DATA_WIDTH];
                if (acc && req_write_i) begin
                    cfg_d[DATA_WIDTH*i +: DATA_WIDTH] = write_data_i;
                    stb_d[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_STATUS_REG; i++) begin
            if (sidx == (ADDR_WIDTH+1)'(i)) begin
                sts_rd     = sts_word[DATA_WIDTH*i +: DATA_WIDTH];
                has_sticky = |STATUS_STICKY_MASK[DATA_WIDTH*i +: DATA_WIDTH];
                if (acc && req_write_i)
                    clr[DATA_WIDTH*i +: DATA_WIDTH] = write_data_i & STATUS_STICKY_MASK[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b0;
            cfg_q        <= CONFIG_RESET;
            cfg_wr_stb_o <= '0;
            sticky_q     <= '0;
        end else begin
            cfg_q        <= cfg_d;
            cfg_wr_stb_o <= stb_d;
            sticky_q     <= ((sticky_q & ~clr) | sync) & STATUS_STICKY_MASK;
            if (acc) begin
                state_q     <= RESP;
                resp_data_o <= req_write_i ? '0 : is_cfg ? cfg_rd : is_sts ? sts_rd : '1;
                resp_err_o  <= !(is_cfg || (is_sts && (!req_write_i || has_sticky)));
            end else if (resp_ready_i) begin
                state_q <= IDLE;
            end
        end
    end
endmodule
